// File: rtl/hsv_window_ctrl.sv
// hsv_window_ctrl: realigns sync strobes to HSV output, windows pixels and counts matches per frame
module hsv_window_ctrl #(
  parameter int LAT   = 3,
  parameter int CNT_W = 20
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             i_de,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic [23:0]      hsv24,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic             o_de,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_mask,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             frame_done,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} state_t;
  localparam logic [5:0][7:0] WIN_RST = {8'd255, 8'd0, 8'd255, 8'd0, 8'd179, 8'd0};
  state_t state, state_nx;
  logic [LAT:0] de_d, hs_d, vs_d;
  logic [5:0][7:0] sh, act;
  logic [CNT_W-1:0] acc;
  logic [7:0] h, s, v;
  logic de_a, vs_a, vs_rise, h_ok, match;
  assign {h, s, v} = hsv24;
  // bit LAT-1 lines up with hsv24, bit LAT is the extra output stage
  assign de_a = de_d[LAT-1];
  assign vs_a = vs_d[LAT-1];
  assign vs_rise = vs_a & ~vs_d[LAT];
  assign o_de = de_d[LAT];
  assign o_hs = hs_d[LAT];
  assign o_vs = vs_d[LAT];
  assign busy = state == ACTIVE;
  assign h_ok = act[0] <= act[1] ? (h >= act[0] && h <= act[1]) : (h >= act[0] || h <= act[1]);
  assign match = h_ok && s >= act[2] && s <= act[3] && v >= act[4] && v <= act[5];
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (enable ? WAIT : IDLE)
             : state == WAIT ? (!enable ? IDLE : vs_rise ? ACTIVE : WAIT)
             : (enable ? ACTIVE : IDLE);
  end
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state <= IDLE;
      de_d <= '0;
      hs_d <= '0;
      vs_d <= '0;
      sh <= WIN_RST;
      act <= WIN_RST;
      acc <= '0;
      frame_cnt <= '0;
      frame_done <= 1'b0;
      o_mask <= 1'b0;
    end else begin
      state <= state_nx;
      de_d <= {de_d[LAT-1:0], i_de};
      hs_d <= {hs_d[LAT-1:0], i_hs};
      vs_d <= {vs_d[LAT-1:0], i_vs};
      if (cfg_we && cfg_addr < 3'd6) sh[cfg_addr] <= cfg_wdata;
      if (vs_rise) act <= sh;
      o_mask <= de_a & match;
      frame_done <= state == ACTIVE && vs_rise;
      if (state == ACTIVE && vs_rise) frame_cnt <= acc;
      acc <= (state != ACTIVE || vs_rise || !enable) ? '0 : acc + CNT_W'(de_a & match & ~&acc);
    end
  end
endmodule

// File: tb/tb_hsv_window_ctrl.sv
// tb_hsv_window_ctrl: scoreboard bench for mask, frame counts (20-bit and saturating 4-bit) and control timing
module tb_hsv_window_ctrl;
  localparam int LAT = 3;
  logic pclk = 0, rst_n = 0, i_de = 0, i_hs = 0, i_vs = 0, enable = 0, cfg_we = 0;
  logic [23:0] hsv24 = '0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic o_de, o_hs, o_vs, o_mask, frame_done, busy;
  logic o_de4, o_hs4, o_vs4, o_mask4, frame_done4, busy4;
  logic [19:0] frame_cnt;
  logic [3:0] frame_cnt4;
  int checks = 0, fails = 0;
  bit mon = 0;
  bit mq[$];
  int cq[$];
  logic [23:0] pix_in = '0;
  logic [23:0] hpipe [LAT];
  logic [7:0] m_sh [6] = '{8'd0, 8'd179, 8'd0, 8'd255, 8'd0, 8'd255};
  logic [7:0] m_act [6] = '{8'd0, 8'd179, 8'd0, 8'd255, 8'd0, 8'd255};
  bit m_active = 0;
  int m_acc = 0;

  hsv_window_ctrl #(.LAT(LAT), .CNT_W(20)) dut (
    .pclk(pclk), .rst_n(rst_n), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs), .hsv24(hsv24),
    .enable(enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs), .o_mask(o_mask), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .busy(busy));

  hsv_window_ctrl #(.LAT(LAT), .CNT_W(4)) dut4 (
    .pclk(pclk), .rst_n(rst_n), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs), .hsv24(hsv24),
    .enable(enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .o_de(o_de4), .o_hs(o_hs4), .o_vs(o_vs4), .o_mask(o_mask4), .frame_cnt(frame_cnt4),
    .frame_done(frame_done4), .busy(busy4));

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit m_match(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v);
    bit hue;
    hue = (m_act[0] <= m_act[1]) ? (h >= m_act[0] && h <= m_act[1]) : (h >= m_act[0] || h <= m_act[1]);
    return hue && s >= m_act[2] && s <= m_act[3] && v >= m_act[4] && v <= m_act[5];
  endfunction

  // converter model: hsv24 follows the pixel driven with i_de by LAT cycles
  task automatic tick();
    @(posedge pclk);
    #1;
    for (int i = LAT - 1; i > 0; i--) hpipe[i] = hpipe[i-1];
    hpipe[0] = pix_in;
    hsv24 = hpipe[LAT-1];
  endtask

  task automatic pixel(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v);
    bit m;
    m = m_match(h, s, v);
    mq.push_back(m);
    if (m_active && m) m_acc++;
    i_de = 1;
    pix_in = {h, s, v};
    tick();
  endtask

  task automatic idle(input int n);
    i_de = 0;
    i_hs = 0;
    repeat (n) tick();
  endtask

  task automatic cfg(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1;
    cfg_addr = a;
    cfg_wdata = d;
    m_sh[a] = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic set_en(input bit e);
    enable = e;
    if (!e) begin
      m_active = 0;
      m_acc = 0;
    end
    tick();
    tick();
  endtask

  // vsync pulse; optional cfg write lands in the same cycle as vs_rise
  task automatic vs(input bit wr, input logic [2:0] a, input logic [7:0] d);
    if (m_active) cq.push_back(m_acc);
    m_act = m_sh;
    m_active = enable;
    m_acc = 0;
    i_de = 0;
    i_vs = 1;
    tick();
    i_vs = 0;
    repeat (LAT - 1) tick();
    if (wr) begin
      cfg_we = 1;
      cfg_addr = a;
      cfg_wdata = d;
      m_sh[a] = d;
    end
    tick();
    cfg_we = 0;
    repeat (LAT + 1) tick();
    chk("busy", busy, m_active);
  endtask

  always @(negedge pclk) begin
    if (mon) begin
      if (o_de) begin
        chk("mask_q_empty", mq.size() == 0, 0);
        if (mq.size() != 0) chk("mask", o_mask, mq.pop_front());
      end else if (o_mask) chk("mask_without_de", o_mask, 0);
      if (frame_done) begin
        chk("cnt_q_empty", cq.size() == 0, 0);
        if (cq.size() != 0) begin
          int n;
          n = cq.pop_front();
          chk("frame_cnt", frame_cnt, n);
          chk("frame_cnt4", frame_cnt4, n > 15 ? 15 : n);
          chk("done_vs_align", o_vs, 1);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < LAT; i++) hpipe[i] = '0;
    i_de = 1;
    i_vs = 1;
    tick();
    tick();
    i_de = 0;
    i_vs = 0;
    chk("rst_o_de", o_de, 0);
    chk("rst_o_hs", o_hs, 0);
    chk("rst_o_vs", o_vs, 0);
    chk("rst_o_mask", o_mask, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    idle(LAT + 2);
    mon = 1;
    i_hs = 1;
    pixel(8'd0, 8'd0, 8'd0);
    idle(2);
    chk("lat_o_de_early", o_de, 0);
    tick();
    chk("lat_o_de", o_de, 1);
    chk("lat_o_hs", o_hs, 1);
    idle(3);
    cfg(3'd0, 8'd20);
    cfg(3'd1, 8'd40);
    set_en(1);
    vs(0, 3'd0, 8'd0);
    for (int i = 0; i < 100; i++)
      pixel(((i * 7) % 100 < 37) ? 8'd30 : 8'd90, 8'($urandom), 8'($urandom));
    idle(2);
    cfg(3'd0, 8'd170);
    cfg(3'd1, 8'd10);
    vs(0, 3'd0, 8'd0);
    pixel(8'd175, 8'd9, 8'd9);
    pixel(8'd5, 8'd9, 8'd9);
    pixel(8'd90, 8'd9, 8'd9);
    idle(2);
    cfg(3'd0, 8'd20);
    cfg(3'd1, 8'd30);
    vs(0, 3'd0, 8'd0);
    repeat (4) pixel(8'd45, 8'd50, 8'd50);
    idle(1);
    cfg(3'd1, 8'd50);
    repeat (4) pixel(8'd45, 8'd50, 8'd50);
    idle(2);
    vs(0, 3'd0, 8'd0);
    repeat (4) pixel(8'd45, 8'd50, 8'd50);
    idle(2);
    vs(1, 3'd0, 8'd100);
    pixel(8'd30, 8'd1, 8'd1);
    pixel(8'd120, 8'd1, 8'd1);
    idle(2);
    vs(0, 3'd0, 8'd0);
    pixel(8'd30, 8'd1, 8'd1);
    pixel(8'd120, 8'd1, 8'd1);
    idle(2);
    cfg(3'd0, 8'd0);
    cfg(3'd1, 8'd179);
    cfg(3'd2, 8'd200);
    cfg(3'd3, 8'd100);
    vs(0, 3'd0, 8'd0);
    repeat (4) pixel(8'($urandom_range(0, 179)), 8'($urandom), 8'($urandom));
    idle(2);
    cfg(3'd2, 8'd0);
    cfg(3'd3, 8'd255);
    vs(0, 3'd0, 8'd0);
    repeat (20) pixel(8'($urandom_range(0, 179)), 8'($urandom), 8'($urandom));
    idle(2);
    vs(0, 3'd0, 8'd0);
    repeat (5) pixel(8'd60, 8'd60, 8'd60);
    idle(LAT + 3);
    set_en(0);
    chk("abort_busy", busy, 0);
    chk("abort_frame_cnt", frame_cnt, 20);
    chk("abort_frame_cnt4", frame_cnt4, 15);
    vs(0, 3'd0, 8'd0);
    idle(LAT + 3);
    chk("mask_q_left", mq.size(), 0);
    chk("cnt_q_left", cq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
